// File: rtl/vga_sync_decoder.sv
`timescale 1ns/1ps
// VGA sync decoder: measures line/frame timing, tracks active-pixel coordinates and locks to a stable source.
// Statistics outputs frame_cnt/err_cnt are only built when VGA_DEC_STATS_EN is defined.
//
// state   | meaning
// SEARCH  | waiting for a vs falling edge
// MEASURE | capturing reference line length, then reference frame length
// VERIFY  | counting consecutive frames that match the reference
// LOCK    | timing stable; any deviation sets err and restarts the search
module vga_sync_decoder #(
    parameter int         LOCK_FRAMES = 2,
    parameter logic [9:0] MAX_CNT     = 10'd1023
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pix_en,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        de_in,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic        rx_de,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic        locked,
    output logic        err,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);
    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCK} state_t;

    state_t     state_q;
    logic       hs_q, vs_q, de_q;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic [9:0] line_len_q, frame_lines_q;
    logic [9:0] rx_x_q, rx_y_q;
    logic       rx_de_q, locked_q, err_q, frame_start_q;
    logic [9:0] ref_line_q, ref_frame_q;
    logic [7:0] match_q;
    logic       have_line_q;

    logic       hs_fall, vs_fall, de_rise, de_fall, hs_lost;
    logic [9:0] line_new, frame_new;
    logic       line_bad, frame_bad, err_evt;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v >= MAX_CNT) ? MAX_CNT : v + 10'd1;
    endfunction

    assign hs_fall   = pix_en & hs_q & ~hs_in;
    assign vs_fall   = pix_en & vs_q & ~vs_in;
    assign de_rise   = pix_en & ~de_q & de_in;
    assign de_fall   = pix_en & de_q & ~de_in;
    // hs lost: the line counter is about to hit saturation without a falling edge
    assign hs_lost   = pix_en & ~hs_fall & (hcnt_q == MAX_CNT - 10'd1);
    assign line_new  = sat_inc(hcnt_q);
    assign frame_new = sat_inc(vcnt_q);
    assign line_bad  = (hs_fall & (line_new != ref_line_q)) | hs_lost;
    assign frame_bad = vs_fall & (frame_new != ref_frame_q);
    assign err_evt   = (state_q == LOCK) & (line_bad | frame_bad);

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_en) hcnt_d = hs_fall ? 10'd0 : sat_inc(hcnt_q);
        if (vs_fall)      vcnt_d = 10'd0;
        else if (hs_fall) vcnt_d = sat_inc(vcnt_q);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            de_q          <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            rx_x_q        <= '0;
            rx_y_q        <= '0;
            rx_de_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_start_q <= vs_fall;
            if (pix_en) begin
                hs_q    <= hs_in;
                vs_q    <= vs_in;
                de_q    <= de_in;
                rx_de_q <= de_in;
            end
            if (hs_fall | hs_lost) line_len_q <= line_new;
            if (vs_fall) frame_lines_q <= frame_new;
            if (de_rise)               rx_x_q <= '0;
            else if (pix_en & de_in)   rx_x_q <= rx_x_q + 10'd1;
            if (vs_fall)      rx_y_q <= '0;
            else if (de_fall) rx_y_q <= rx_y_q + 10'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= SEARCH;
            ref_line_q  <= '0;
            ref_frame_q <= '0;
            match_q     <= '0;
            have_line_q <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (vs_fall) begin
                        state_q     <= MEASURE;
                        have_line_q <= 1'b0;
                    end
                end
                MEASURE: begin
                    // the edge that enters MEASURE closes a line from before; only later edges count
                    if (hs_fall && !have_line_q) begin
                        ref_line_q  <= line_new;
                        have_line_q <= 1'b1;
                    end
                    if (vs_fall && (have_line_q || hs_fall)) begin
                        ref_frame_q <= frame_new;
                        match_q     <= '0;
                        state_q     <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (line_bad || frame_bad) begin
                        state_q     <= MEASURE;
                        have_line_q <= 1'b0;
                    end else if (vs_fall) begin
                        if (int'(match_q) + 1 >= LOCK_FRAMES) begin
                            state_q  <= LOCK;
                            locked_q <= 1'b1;
                        end else begin
                            match_q <= match_q + 8'd1;
                        end
                    end
                end
                LOCK: begin
                    if (err_evt) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        err_q    <= 1'b1;
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

`ifdef VGA_DEC_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (vs_fall) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (err_evt && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

    assign rx_x        = rx_x_q;
    assign rx_y        = rx_y_q;
    assign rx_de       = rx_de_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
`timescale 1ns/1ps
// Bench for vga_sync_decoder using a scaled-down raster (64 strobes x 24 lines) driven every other clock.
module tb_vga_sync_decoder;
    localparam int H_TOT  = 64;
    localparam int H_SYNC = 8;
    localparam int H_ACT  = 16;
    localparam int ACT_W  = 40;
    localparam int V_TOT  = 24;
    localparam int V_SYNC = 2;
    localparam int V_ACT  = 5;
    localparam int ACT_H  = 16;
`ifdef VGA_DEC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic        de_in = 1'b0;
    logic [9:0]  rx_x, rx_y, line_len, frame_lines;
    logic        rx_de, locked, err, frame_start;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int fs_cnt  = 0;
    int rst_snap = 0;
    logic [20:0] sb_q[$];

    typedef struct {
        int         short_line;
        bit         sb;
        logic       locked;
        logic       err;
        logic [9:0] line_len;
        logic [9:0] frame_lines;
        int         errs;
    } vec_t;
    vec_t tbl[10];

    vga_sync_decoder dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en),
        .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .rx_x(rx_x), .rx_y(rx_y), .rx_de(rx_de),
        .line_len(line_len), .frame_lines(frame_lines),
        .locked(locked), .err(err), .frame_start(frame_start),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #10 Clk = ~Clk;

    always @(negedge Clk) if (frame_start) fs_cnt++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic gen(input int l, input int p, output logic hs, output logic vs, output logic de);
        hs = (p >= H_SYNC);
        vs = (l >= V_SYNC);
        de = (l >= V_ACT) && (l < V_ACT + ACT_H) && (p >= H_ACT) && (p < H_ACT + ACT_W);
    endtask

    function automatic logic [20:0] exp_rx(input int l, input int p);
        logic       de;
        logic [9:0] x, y;
        de = (l >= V_ACT) && (l < V_ACT + ACT_H) && (p >= H_ACT) && (p < H_ACT + ACT_W);
        x  = de ? 10'(p - H_ACT) : 10'(ACT_W - 1);
        if (l < V_ACT)              y = 10'd0;
        else if (l >= V_ACT + ACT_H) y = 10'(ACT_H);
        else if (p >= H_ACT + ACT_W) y = 10'(l - V_ACT + 1);
        else                         y = 10'(l - V_ACT);
        return {de, x, y};
    endfunction

    task automatic strobe(input logic hs, input logic vs, input logic de);
        hs_in  = hs;
        vs_in  = vs;
        de_in  = de;
        pix_en = 1'b1;
        @(posedge Clk);
        #1 pix_en = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        #3 Reset_n = 1'b0;
        #1;
        check("rst_all_zero",
              32'(|{rx_x, rx_y, rx_de, line_len, frame_lines, locked, err, frame_start, frame_cnt, err_cnt}), 0);
        rst_snap = fs_cnt;
        #4 Reset_n = 1'b1;
    endtask

    task automatic drive_frame(input int short_line, input int rst_line, input bit sb_en);
        logic hs, vs, de;
        logic [20:0] e;
        int hl;
        for (int l = 0; l < V_TOT; l++) begin
            hl = (l == short_line) ? H_TOT - 1 : H_TOT;
            for (int p = 0; p < hl; p++) begin
                if (l == rst_line && p == 30) do_reset();
                gen(l, p, hs, vs, de);
                if (sb_en) sb_q.push_back(exp_rx(l, p));
                strobe(hs, vs, de);
                if (sb_en) begin
                    e = sb_q.pop_front();
                    check("rx_de_x_y", 32'({rx_de, rx_x, rx_y}), 32'(e));
                end
                if (short_line >= 0 && l == short_line && p == 0)
                    check("locked_before_short", 32'(locked), 1);
                if (short_line >= 0 && l == short_line + 1 && p == 0) begin
                    check("short_locked", 32'(locked), 0);
                    check("short_err", 32'(err), 1);
                    check("short_line_len", 32'(line_len), 63);
                    check("short_err_cnt", 32'(err_cnt), STATS ? 1 : 0);
                end
            end
        end
    endtask

    initial begin
        logic hs, vs, de;
        tbl[0] = '{-1, 1'b0, 1'b0, 1'b0, 10'd64, 10'd1,  0};
        tbl[1] = '{-1, 1'b0, 1'b0, 1'b0, 10'd64, 10'd24, 0};
        tbl[2] = '{-1, 1'b0, 1'b0, 1'b0, 10'd64, 10'd24, 0};
        tbl[3] = '{-1, 1'b0, 1'b1, 1'b0, 10'd64, 10'd24, 0};
        tbl[4] = '{-1, 1'b1, 1'b1, 1'b0, 10'd64, 10'd24, 0};
        tbl[5] = '{10, 1'b0, 1'b0, 1'b1, 10'd64, 10'd24, 1};
        tbl[6] = '{-1, 1'b0, 1'b0, 1'b1, 10'd64, 10'd24, 1};
        tbl[7] = '{-1, 1'b0, 1'b0, 1'b1, 10'd64, 10'd24, 1};
        tbl[8] = '{-1, 1'b0, 1'b0, 1'b1, 10'd64, 10'd24, 1};
        tbl[9] = '{-1, 1'b0, 1'b1, 1'b1, 10'd64, 10'd24, 1};

        repeat (3) @(posedge Clk);
        #1;
        check("reset_outputs_zero",
              32'(|{rx_x, rx_y, rx_de, line_len, frame_lines, locked, err, frame_start, frame_cnt, err_cnt}), 0);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            drive_frame(tbl[i].short_line, -1, tbl[i].sb);
            check("frame_locked", 32'(locked), 32'(tbl[i].locked));
            check("frame_err", 32'(err), 32'(tbl[i].err));
            check("frame_line_len", 32'(line_len), 32'(tbl[i].line_len));
            check("frame_lines", 32'(frame_lines), 32'(tbl[i].frame_lines));
            check("frame_start_pulses", 32'(fs_cnt), 32'(i + 1));
            check("frame_cnt", 32'(frame_cnt), STATS ? 32'(i + 1) : 0);
            check("err_cnt", 32'(err_cnt), STATS ? 32'(tbl[i].errs) : 0);
        end

        // hs held high after lock: last falling edge at line 7, pixel 0
        for (int l = 0; l < 8; l++)
            for (int p = 0; p < ((l == 7) ? 1 : H_TOT); p++) begin
                gen(l, p, hs, vs, de);
                strobe(hs, vs, de);
            end
        for (int n = 1; n <= 1023; n++) begin
            if (n < H_TOT) gen(7, n, hs, vs, de);
            else begin hs = 1'b1; vs = 1'b1; de = 1'b0; end
            strobe(hs, vs, de);
            if (n == 1022) check("hs_lost_pre_locked", 32'(locked), 1);
        end
        check("hs_lost_locked", 32'(locked), 0);
        check("hs_lost_err", 32'(err), 1);
        check("hs_lost_line_len", 32'(line_len), 1023);
        check("hs_lost_err_cnt", 32'(err_cnt), STATS ? 2 : 0);

        // reset pulsed mid-line, then recovery from a fresh vs edge
        drive_frame(-1, -1, 1'b0);
        check("post_lost_locked", 32'(locked), 0);
        drive_frame(-1, 10, 1'b0);
        check("no_fs_after_rst", 32'(fs_cnt), 32'(rst_snap));
        check("rst_frame_lines", 32'(frame_lines), 0);
        check("rst_err_cleared", 32'(err), 0);
        check("rst_locked", 32'(locked), 0);
        drive_frame(-1, -1, 1'b0);
        check("fs_after_rst", 32'(fs_cnt), 32'(rst_snap + 1));
        check("partial_frame_lines", 32'(frame_lines), 14);
        drive_frame(-1, -1, 1'b0);
        check("coincident_frame_lines", 32'(frame_lines), 24);
        check("coincident_line_len", 32'(line_len), 64);
        check("fs_second", 32'(fs_cnt), 32'(rst_snap + 2));
        check("frame_cnt_after_rst", 32'(frame_cnt), STATS ? 2 : 0);
        check("err_cnt_after_rst", 32'(err_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
